// File: rtl/fe_bp_fetch_pkg.sv
// Shared definitions for the fe_bp_fetch fetch stage and its predictor tables.
// Contents:
//   PtResetVal     - pattern-table counter value after reset (weakly not-taken)
//   tag_bits()     - BTB tag width for a given PC width and BTB index width
//   fe_latch_bits()- total width of the FE->DE latch for a given configuration
//   fe_ctrl_t      - prediction/valid control fields of the FE->DE latch
package fe_bp_fetch_pkg;

  localparam logic [1:0] PtResetVal = 2'b01;

  // PC bits above the BTB index and the byte offset form the tag.
  function automatic int unsigned tag_bits(input int unsigned dbits,
                                           input int unsigned btb_idx_bits);
    return dbits - btb_idx_bits - 2;
  endfunction

  // valid + inst + pc + pcplus + pred_taken + pred_target + pt_idx + count
  function automatic int unsigned fe_latch_bits(input int unsigned dbits,
                                                input int unsigned instbits,
                                                input int unsigned pt_idx_bits);
    return 2 + instbits + 4 * dbits + pt_idx_bits;
  endfunction

  typedef struct packed {
    logic valid;
    logic pred_taken;
  } fe_ctrl_t;

endpackage

// File: rtl/fe_bp_fetch_tables.sv
// Predictor storage for fe_bp_fetch: pattern table of 2-bit saturating counters,
// direct-mapped BTB and, when FE_BP_GSHARE_EN is defined, a global history register.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   rd_pt_idx_i/rd_btb_idx_i - combinational lookup indices
//   rd_pt_ctr_o             - counter at rd_pt_idx_i
//   rd_btb_valid/tag/target - BTB entry at rd_btb_idx_i
//   bhr_o                   - global history (FE_BP_GSHARE_EN only)
//   upd_*                   - training port, applied on the rising edge
// Reads return pre-edge contents, so a same-cycle update is seen one cycle later.
module fe_bp_fetch_tables
  import fe_bp_fetch_pkg::*;
#(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned PT_IDX_BITS  = 8,
  parameter int unsigned BTB_IDX_BITS = 4,
  parameter int unsigned BHR_BITS     = 8,
  parameter int unsigned TAG_BITS     = 26
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PT_IDX_BITS-1:0]  rd_pt_idx_i,
  input  logic [BTB_IDX_BITS-1:0] rd_btb_idx_i,
  output logic [1:0]              rd_pt_ctr_o,
  output logic                    rd_btb_valid_o,
  output logic [TAG_BITS-1:0]     rd_btb_tag_o,
  output logic [DBITS-1:0]        rd_btb_target_o,
`ifdef FE_BP_GSHARE_EN
  output logic [BHR_BITS-1:0]     bhr_o,
`endif
  input  logic                    upd_valid_i,
  input  logic                    upd_taken_i,
  input  logic [PT_IDX_BITS-1:0]  upd_pt_idx_i,
  input  logic [BTB_IDX_BITS-1:0] upd_btb_idx_i,
  input  logic [TAG_BITS-1:0]     upd_tag_i,
  input  logic [DBITS-1:0]        upd_target_i
);

  localparam int unsigned PtEntries  = 1 << PT_IDX_BITS;
  localparam int unsigned BtbEntries = 1 << BTB_IDX_BITS;

  logic [1:0]          pt_q     [PtEntries];
  logic [1:0]          pt_d     [PtEntries];
  logic [BtbEntries-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_BITS-1:0] btb_tag_q  [BtbEntries];
  logic [TAG_BITS-1:0] btb_tag_d  [BtbEntries];
  logic [DBITS-1:0]    btb_tgt_q  [BtbEntries];
  logic [DBITS-1:0]    btb_tgt_d  [BtbEntries];
  logic [1:0]          upd_ctr;

  always_comb begin
    pt_d        = pt_q;
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    upd_ctr     = pt_q[upd_pt_idx_i];
    if (upd_valid_i) begin
      if (upd_taken_i && upd_ctr != 2'b11) begin
        pt_d[upd_pt_idx_i] = upd_ctr + 2'b01;
      end else if (!upd_taken_i && upd_ctr != 2'b00) begin
        pt_d[upd_pt_idx_i] = upd_ctr - 2'b01;
      end
      // Not-taken outcomes carry no useful target, so the BTB is left alone.
      if (upd_taken_i) begin
        btb_valid_d[upd_btb_idx_i] = 1'b1;
        btb_tag_d[upd_btb_idx_i]   = upd_tag_i;
        btb_tgt_d[upd_btb_idx_i]   = upd_target_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PtEntries; i++) pt_q[i] <= PtResetVal;
      btb_valid_q <= '0;
      for (int i = 0; i < BtbEntries; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else begin
      pt_q        <= pt_d;
      btb_valid_q <= btb_valid_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
    end
  end

`ifdef FE_BP_GSHARE_EN
  logic [BHR_BITS-1:0] bhr_q, bhr_d;

  always_comb begin
    bhr_d = bhr_q;
    if (upd_valid_i) bhr_d = (bhr_q << 1) | BHR_BITS'(upd_taken_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bhr_q <= '0;
    else          bhr_q <= bhr_d;
  end

  assign bhr_o = bhr_q;
`endif

  assign rd_pt_ctr_o     = pt_q[rd_pt_idx_i];
  assign rd_btb_valid_o  = btb_valid_q[rd_btb_idx_i];
  assign rd_btb_tag_o    = btb_tag_q[rd_btb_idx_i];
  assign rd_btb_target_o = btb_tgt_q[rd_btb_idx_i];

endmodule

// File: rtl/fe_bp_fetch.sv
// Fetch stage with integrated branch predictor (PT of 2-bit counters + direct-mapped BTB).
// Optional gshare indexing is enabled by defining FE_BP_GSHARE_EN.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   stall_i               - decode cannot accept; hold PC and latch
//   redirect_i/_pc_i      - mispredict redirect from AGEX
//   upd_*                 - predictor training from AGEX
//   imem_addr_o/rdata_i   - combinational instruction memory port
//   fe_*                  - FE->DE pipeline latch
module fe_bp_fetch
  import fe_bp_fetch_pkg::*;
#(
  parameter int unsigned      DBITS        = 32,
  parameter int unsigned      INSTBITS     = 32,
  parameter int unsigned      PT_IDX_BITS  = 8,
  parameter int unsigned      BTB_IDX_BITS = 4,
  parameter int unsigned      BHR_BITS     = 8,
  parameter logic [DBITS-1:0] START_PC     = 'h100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [DBITS-1:0]       redirect_pc_i,
  input  logic                   upd_valid_i,
  input  logic [DBITS-1:0]       upd_pc_i,
  input  logic                   upd_taken_i,
  input  logic [DBITS-1:0]       upd_target_i,
  input  logic [PT_IDX_BITS-1:0] upd_pt_idx_i,
  output logic [DBITS-1:0]       imem_addr_o,
  input  logic [INSTBITS-1:0]    imem_rdata_i,
  output logic                   fe_valid_o,
  output logic [INSTBITS-1:0]    fe_inst_o,
  output logic [DBITS-1:0]       fe_pc_o,
  output logic [DBITS-1:0]       fe_pcplus_o,
  output logic                   fe_pred_taken_o,
  output logic [DBITS-1:0]       fe_pred_target_o,
  output logic [PT_IDX_BITS-1:0] fe_pt_idx_o,
  output logic [DBITS-1:0]       fe_inst_count_o
);

  localparam int unsigned TAG_BITS   = tag_bits(DBITS, BTB_IDX_BITS);
  localparam int unsigned LatchBits  = fe_latch_bits(DBITS, INSTBITS, PT_IDX_BITS);

  if (BHR_BITS > PT_IDX_BITS) begin : g_bhr_check
    $error("BHR_BITS must not exceed PT_IDX_BITS");
  end

  typedef struct packed {
    fe_ctrl_t               ctrl;
    logic [INSTBITS-1:0]    inst;
    logic [DBITS-1:0]       pc;
    logic [DBITS-1:0]       pcplus;
    logic [DBITS-1:0]       pred_target;
    logic [PT_IDX_BITS-1:0] pt_idx;
    logic [DBITS-1:0]       count;
  } fe_latch_t;

  if ($bits(fe_latch_t) != LatchBits) begin : g_latch_check
    $error("FE latch width mismatch");
  end

  logic [DBITS-1:0]        pc_q, pc_d;
  logic [DBITS-1:0]        count_q, count_d;
  fe_latch_t               latch_q, latch_d;

  logic [PT_IDX_BITS-1:0]  pt_idx;
  logic [BTB_IDX_BITS-1:0] btb_idx;
  logic [TAG_BITS-1:0]     pc_tag;
  logic [1:0]              pt_ctr;
  logic                    btb_valid;
  logic [TAG_BITS-1:0]     btb_tag;
  logic [DBITS-1:0]        btb_target;
  logic                    pred_taken;
  logic [DBITS-1:0]        pc_plus4;
  logic [DBITS-1:0]        next_pc;

  assign btb_idx = pc_q[BTB_IDX_BITS+1:2];
  assign pc_tag  = pc_q[DBITS-1:BTB_IDX_BITS+2];

`ifdef FE_BP_GSHARE_EN
  logic [BHR_BITS-1:0]    bhr;
  logic [PT_IDX_BITS-1:0] bhr_ext;

  always_comb begin
    bhr_ext                = '0;
    bhr_ext[BHR_BITS-1:0]  = bhr;
  end

  assign pt_idx = pc_q[PT_IDX_BITS+1:2] ^ bhr_ext;
`else
  assign pt_idx = pc_q[PT_IDX_BITS+1:2];
`endif

  fe_bp_fetch_tables #(
    .DBITS       (DBITS),
    .PT_IDX_BITS (PT_IDX_BITS),
    .BTB_IDX_BITS(BTB_IDX_BITS),
    .BHR_BITS    (BHR_BITS),
    .TAG_BITS    (TAG_BITS)
  ) u_tables (
    .clk            (clk),
    .reset_n        (reset_n),
    .rd_pt_idx_i    (pt_idx),
    .rd_btb_idx_i   (btb_idx),
    .rd_pt_ctr_o    (pt_ctr),
    .rd_btb_valid_o (btb_valid),
    .rd_btb_tag_o   (btb_tag),
    .rd_btb_target_o(btb_target),
`ifdef FE_BP_GSHARE_EN
    .bhr_o          (bhr),
`endif
    .upd_valid_i    (upd_valid_i),
    .upd_taken_i    (upd_taken_i),
    .upd_pt_idx_i   (upd_pt_idx_i),
    .upd_btb_idx_i  (upd_pc_i[BTB_IDX_BITS+1:2]),
    .upd_tag_i      (upd_pc_i[DBITS-1:BTB_IDX_BITS+2]),
    .upd_target_i   (upd_target_i)
  );

  // Only the counter's direction bit matters for lookup; PC byte offset never indexes.
  logic unused_bits;
  assign unused_bits = ^{pt_ctr[0], upd_pc_i[1:0]};

  assign pc_plus4   = pc_q + DBITS'(4);
  assign pred_taken = btb_valid && (btb_tag == pc_tag) && pt_ctr[1];
  assign next_pc    = pred_taken ? btb_target : pc_plus4;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    latch_d = latch_q;
    if (redirect_i) begin
      pc_d                = redirect_pc_i;
      latch_d.ctrl.valid  = 1'b0;
    end else if (!stall_i) begin
      pc_d                    = next_pc;
      latch_d.ctrl.valid      = 1'b1;
      latch_d.ctrl.pred_taken = pred_taken;
      latch_d.inst            = imem_rdata_i;
      latch_d.pc              = pc_q;
      latch_d.pcplus          = pc_plus4;
      latch_d.pred_target     = next_pc;
      latch_d.pt_idx          = pt_idx;
      latch_d.count           = count_q;
      count_d                 = count_q + DBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= START_PC;
      count_q       <= DBITS'(1);
      latch_q       <= '0;
      latch_q.count <= DBITS'(1);
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      latch_q <= latch_d;
    end
  end

  assign imem_addr_o      = pc_q;
  assign fe_valid_o       = latch_q.ctrl.valid;
  assign fe_inst_o        = latch_q.inst;
  assign fe_pc_o          = latch_q.pc;
  assign fe_pcplus_o      = latch_q.pcplus;
  assign fe_pred_taken_o  = latch_q.ctrl.pred_taken;
  assign fe_pred_target_o = latch_q.pred_target;
  assign fe_pt_idx_o      = latch_q.pt_idx;
  assign fe_inst_count_o  = latch_q.count;

endmodule

// File: tb/tb_fe_bp_fetch.sv
// Self-checking bench for fe_bp_fetch: directed scenarios followed by random traffic,
// all checked against a behavioural model of the fetch/predict rules.
module tb_fe_bp_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, redirect_i, upd_valid_i, upd_taken_i;
  logic [31:0] redirect_pc_i, upd_pc_i, upd_target_i;
  logic [7:0]  upd_pt_idx_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        fe_valid_o, fe_pred_taken_o;
  logic [31:0] fe_inst_o, fe_pc_o, fe_pcplus_o, fe_pred_target_o, fe_inst_count_o;
  logic [7:0]  fe_pt_idx_o;

  always #5 clk = ~clk;

  assign imem_rdata_i = 32'hA0 + imem_addr_o;

  fe_bp_fetch dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .upd_valid_i     (upd_valid_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i),
    .upd_pt_idx_i    (upd_pt_idx_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .fe_valid_o      (fe_valid_o),
    .fe_inst_o       (fe_inst_o),
    .fe_pc_o         (fe_pc_o),
    .fe_pcplus_o     (fe_pcplus_o),
    .fe_pred_taken_o (fe_pred_taken_o),
    .fe_pred_target_o(fe_pred_target_o),
    .fe_pt_idx_o     (fe_pt_idx_o),
    .fe_inst_count_o (fe_inst_count_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          pt [256];
  bit          bv [16];
  logic [31:0] btgt [16];
  logic [31:0] btag [16];
  logic [7:0]  bhr;
  logic [31:0] m_pc, m_count;
  bit          m_lv, m_known;
  logic [31:0] m_inst, m_lpc, m_lpcplus, m_ltgt, m_lcount;
  bit          m_lpred;
  logic [7:0]  m_lidx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 256; i++) pt[i] = 1;
    for (int i = 0; i < 16; i++) begin bv[i] = 0; btgt[i] = 0; btag[i] = 0; end
    bhr = 0; m_pc = 32'h100; m_count = 1;
    m_lv = 0; m_known = 1; m_inst = 0; m_lpc = 0; m_lpcplus = 0; m_ltgt = 0;
    m_lcount = 1; m_lpred = 0; m_lidx = 0;
  endtask

  // One rising edge of the spec's behaviour, using current inputs and pre-edge state.
  task automatic m_edge();
    int idx, bi, ui;
    bit hit, ptk;
    logic [31:0] nxt;
    idx = (m_pc / 4) % 256;
`ifdef FE_BP_GSHARE_EN
    idx = idx ^ int'(bhr);
`endif
    bi  = (m_pc / 4) % 16;
    hit = bv[bi] && (btag[bi] == m_pc / 64);
    ptk = hit && (pt[idx] >= 2);
    nxt = ptk ? btgt[bi] : m_pc + 4;
    if (redirect_i) begin
      m_pc = redirect_pc_i; m_lv = 0; m_known = 0;
    end else if (!stall_i) begin
      m_lv = 1; m_known = 1; m_inst = 32'hA0 + m_pc; m_lpc = m_pc; m_lpcplus = m_pc + 4;
      m_lpred = ptk; m_ltgt = nxt; m_lidx = 8'(idx); m_lcount = m_count;
      m_count = m_count + 1; m_pc = nxt;
    end
    if (upd_valid_i) begin
      ui = int'(upd_pt_idx_i);
      if (upd_taken_i) begin
        if (pt[ui] < 3) pt[ui] = pt[ui] + 1;
        bi = (upd_pc_i / 4) % 16;
        bv[bi] = 1; btag[bi] = upd_pc_i / 64; btgt[bi] = upd_target_i;
      end else if (pt[ui] > 0) begin
        pt[ui] = pt[ui] - 1;
      end
      bhr = {bhr[6:0], upd_taken_i};
    end
  endtask

  task automatic cmp_all();
    chk("imem_addr", imem_addr_o, m_pc);
    chk("fe_valid", 32'(fe_valid_o), 32'(m_lv));
    if (m_known) begin
      chk("fe_inst", fe_inst_o, m_inst);
      chk("fe_pc", fe_pc_o, m_lpc);
      chk("fe_pcplus", fe_pcplus_o, m_lpcplus);
      chk("fe_pred_taken", 32'(fe_pred_taken_o), 32'(m_lpred));
      chk("fe_pred_target", fe_pred_target_o, m_ltgt);
      chk("fe_pt_idx", 32'(fe_pt_idx_o), 32'(m_lidx));
      chk("fe_inst_count", fe_inst_count_o, m_lcount);
    end
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit uv,
                      input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                      input logic [7:0] uidx);
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
    upd_pt_idx_i = uidx;
    m_edge();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rp, up, ut;
    logic [7:0]  ui;
    reset_n = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0; upd_valid_i = 0;
    upd_pc_i = 0; upd_taken_i = 0; upd_target_i = 0; upd_pt_idx_i = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    chk("rst_count", fe_inst_count_o, 32'd1);
    chk("rst_addr", imem_addr_o, 32'h100);
    reset_n = 1;

    // Sequential fetch from START_PC
    idle(); chk("seq_pc0", fe_pc_o, 32'h100); chk("seq_cnt0", fe_inst_count_o, 32'd1);
    idle(); chk("seq_pc1", fe_pc_o, 32'h104); chk("seq_cnt1", fe_inst_count_o, 32'd2);
    idle(); chk("seq_pc2", fe_pc_o, 32'h108); chk("seq_cnt2", fe_inst_count_o, 32'd3);
    chk("seq_pred", 32'(fe_pred_taken_o), 32'd0);

    // Stall holds latch and PC
    repeat (3) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("stall_pc", fe_pc_o, 32'h108);
      chk("stall_addr", imem_addr_o, 32'h10C);
    end
    idle(); chk("resume_pc", fe_pc_o, 32'h10C);

    // Redirect: one bubble then refetch
    step(0, 1, 32'h200, 0, 0, 0, 0, 0); chk("redir_bubble", 32'(fe_valid_o), 32'd0);
    idle(); chk("redir_pc", fe_pc_o, 32'h200);

    // Train 0x120 -> 0x300 taken twice, then fetch it
    step(0, 0, 0, 1, 32'h120, 1, 32'h300, 8'h48);
    step(0, 0, 0, 1, 32'h120, 1, 32'h300, 8'h48);
    step(0, 1, 32'h120, 0, 0, 0, 0, 0);
    idle();
`ifndef FE_BP_GSHARE_EN
    chk("bp_taken", 32'(fe_pred_taken_o), 32'd1);
    chk("bp_target", imem_addr_o, 32'h300);
`endif
    // Saturate counter up, then four not-taken updates down to 0
    step(1, 0, 0, 1, 32'h120, 1, 32'h300, 8'h48);
    repeat (4) step(1, 0, 0, 1, 32'h120, 0, 32'h0, 8'h48);
    step(0, 1, 32'h120, 0, 0, 0, 0, 0);
    idle();
    chk("bp_sat_nt", 32'(fe_pred_taken_o), 32'd0);
    chk("bp_sat_addr", imem_addr_o, 32'h124);

    // Update concurrent with redirect and stall still trains
    step(1, 1, 32'h140, 1, 32'h140, 1, 32'h3C0, 8'h50);
    idle();
`ifndef FE_BP_GSHARE_EN
    chk("upd_redir_taken", 32'(fe_pred_taken_o), 32'd1);
    chk("upd_redir_tgt", imem_addr_o, 32'h3C0);
`endif
    idle();

    // Asynchronous reset mid-operation
    #2 reset_n = 0;
    #1;
    m_reset();
    cmp_all();
    #3 reset_n = 1;
    @(posedge clk); #1;
    m_edge();  // idle inputs: the model edge matches the first post-reset edge
    stall_i = 0; redirect_i = 0; upd_valid_i = 0;
    cmp_all();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rp = 32'h100 + 4 * $urandom_range(0, 15);
      up = 32'h100 + 4 * $urandom_range(0, 15) + ($urandom_range(0, 7) == 0 ? 32'h400 : 0);
      ut = 32'h100 + 4 * $urandom_range(0, 31) + ($urandom_range(0, 3) == 0 ? 32'h400 : 0);
      ui = $urandom_range(0, 1) ? 8'((up / 4) % 256) : 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rp,
           $urandom_range(0, 1) == 1, up, $urandom_range(0, 2) != 0, ut, ui);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
